// File: rtl/fc_tile_scheduler_if.sv
// Mover control/result bus and the outgoing result stream of fc_tile_scheduler.
// master = scheduler side, slave = mover + result consumer side.
interface fc_tile_scheduler_if #(
   parameter int unsigned CNT_BIT = 31,
   parameter int unsigned RWIDTH  = 36
);
   logic                  mv_run;
   logic [CNT_BIT-1:0]    mv_num_cnt;
   logic                  mv_idle;
   logic                  mv_done;
   logic [RWIDTH-1:0]     mv_result_0;
   logic [RWIDTH-1:0]     mv_result_1;
   logic [RWIDTH-1:0]     mv_result_2;
   logic [RWIDTH-1:0]     mv_result_3;
   logic                  res_valid;
   logic                  res_ready;
   logic [4*RWIDTH-1:0]   res_data;
   logic                  res_last;

   modport master (
      output mv_run, mv_num_cnt, res_valid, res_data, res_last,
      input  mv_idle, mv_done, mv_result_0, mv_result_1, mv_result_2, mv_result_3,
             res_ready
   );

   modport slave (
      input  mv_run, mv_num_cnt, res_valid, res_data, res_last,
      output mv_idle, mv_done, mv_result_0, mv_result_1, mv_result_2, mv_result_3,
             res_ready
   );
endinterface

// File: rtl/fc_tile_scheduler.sv
// Job-level sequencer for the 4-core FC data mover: one mover run per tile,
// results drained over a valid/ready stream, with a per-tile watchdog and abort.
module fc_tile_scheduler #(
   parameter int unsigned CNT_BIT  = 31,
   parameter int unsigned TILE_BIT = 8,
   parameter int unsigned RWIDTH   = 36,
   parameter int unsigned WD_BIT   = 21,
   parameter int unsigned TIMEOUT  = 1048576
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic [TILE_BIT-1:0] i_num_tile,
   input  logic [CNT_BIT-1:0]  i_num_cnt,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err_timeout,
   output logic [TILE_BIT-1:0] o_tile_idx,
   fc_tile_scheduler_if.master mv
);

   localparam logic [WD_BIT-1:0] WD_LAST = WD_BIT'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_PUSH   = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } state_e;

   state_e                        state_q, state_d;
   logic [TILE_BIT-1:0]           num_tile_q, num_tile_d;
   logic [TILE_BIT-1:0]           tile_idx_q, tile_idx_d;
   logic [CNT_BIT-1:0]            num_cnt_q, num_cnt_d;
   logic [WD_BIT-1:0]             wd_q, wd_d;
   logic [3:0][RWIDTH-1:0]        res_q, res_d;
   logic                          busy_q, done_q, err_q, valid_q, last_q;
   logic                          mv_run_c;
   logic                          last_tile_c;

   // Next-state, datapath updates and the combinational mover run strobe.
   always_comb begin
      state_d     = state_q;
      num_tile_d  = num_tile_q;
      tile_idx_d  = tile_idx_q;
      num_cnt_d   = num_cnt_q;
      wd_d        = wd_q;
      res_d       = res_q;
      mv_run_c    = 1'b0;
      last_tile_c = (tile_idx_q == (num_tile_q - TILE_BIT'(1)));

      if (i_abort) begin
         // Abort beats everything; results and indices are left untouched.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start && mv.mv_idle) begin
                  num_tile_d = i_num_tile;
                  num_cnt_d  = i_num_cnt;
                  tile_idx_d = '0;
                  if ((i_num_tile == '0) || (i_num_cnt == '0)) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               if (mv.mv_idle) begin
                  mv_run_c = 1'b1;
                  wd_d     = '0;
                  state_d  = S_WAIT;
               end
            end
            S_WAIT: begin
               wd_d = wd_q + WD_BIT'(1);
               if (mv.mv_done) begin
                  res_d[0] = mv.mv_result_0;
                  res_d[1] = mv.mv_result_1;
                  res_d[2] = mv.mv_result_2;
                  res_d[3] = mv.mv_result_3;
                  state_d  = S_PUSH;
               end else if (wd_q == WD_LAST) begin
                  state_d = S_ERR;
               end
            end
            S_PUSH: begin
               if (mv.res_ready) begin
                  if (last_tile_c) begin
                     state_d = S_DONE;
                  end else begin
                     tile_idx_d = tile_idx_q + TILE_BIT'(1);
                     state_d    = S_LAUNCH;
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            S_ERR: begin
               state_d = S_ERR;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State, datapath and registered status flags (decoded from next state).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         num_tile_q <= '0;
         tile_idx_q <= '0;
         num_cnt_q  <= '0;
         wd_q       <= '0;
         res_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_tile_q <= num_tile_d;
         tile_idx_q <= tile_idx_d;
         num_cnt_q  <= num_cnt_d;
         wd_q       <= wd_d;
         res_q      <= res_d;
         busy_q     <= (state_d != S_IDLE);
         done_q     <= (state_d == S_DONE);
         err_q      <= (state_d == S_ERR);
         valid_q    <= (state_d == S_PUSH);
         last_q     <= (state_d == S_PUSH) &&
                       (tile_idx_d == (num_tile_d - TILE_BIT'(1)));
      end
   end

   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_err_timeout = err_q;
   assign o_tile_idx    = tile_idx_q;

   assign mv.mv_run     = mv_run_c;
   assign mv.mv_num_cnt = num_cnt_q;
   assign mv.res_valid  = valid_q;
   assign mv.res_last   = last_q;
   assign mv.res_data   = {res_q[0], res_q[1], res_q[2], res_q[3]};

endmodule

// File: tb/tb_fc_tile_scheduler.sv
// Scoreboard bench for fc_tile_scheduler: stimulus queues expected results,
// a negedge monitor drives ready and checks every presented result.
module tb_fc_tile_scheduler;

   localparam int unsigned CB = 31;
   localparam int unsigned TB = 8;
   localparam int unsigned RW = 36;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          i_start = 1'b0;
   logic          i_abort = 1'b0;
   logic [TB-1:0] i_num_tile = '0;
   logic [CB-1:0] i_num_cnt = '0;
   logic          o_busy, o_done, o_err_timeout;
   logic [TB-1:0] o_tile_idx;

   fc_tile_scheduler_if #(.CNT_BIT(CB), .RWIDTH(RW)) bus ();

   fc_tile_scheduler #(.CNT_BIT(CB), .TILE_BIT(TB), .RWIDTH(RW), .WD_BIT(21), .TIMEOUT(TO)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_start       (i_start),
      .i_abort       (i_abort),
      .i_num_tile    (i_num_tile),
      .i_num_cnt     (i_num_cnt),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_err_timeout (o_err_timeout),
      .o_tile_idx    (o_tile_idx),
      .mv            (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4*RW-1:0] data;
      logic            last;
      logic [TB-1:0]   idx;
   } exp_t;

   exp_t          exp_q[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            run_cnt = 0;
   int            done_cnt = 0;
   int            first_run_cyc = -1;
   int            last_hs_cyc = -1;
   int            job_id = 0;
   int            stall_tile = -1;
   int            stall_n = 0;
   logic [CB-1:0] exp_cnt = '0;
   bit            mv_hang = 1'b0;

   task automatic check(input string nm, input logic [159:0] got, input logic [159:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, want);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   function automatic logic [4*RW-1:0] tile_data(input int t);
      return {RW'(4*t+1), RW'(4*t+2), RW'(4*t+3), RW'(4*t+4)};
   endfunction

   // Monitor: drives ready, checks the stream against the scoreboard, counts events.
   int   mon_job = 0;
   int   stall_used = 0;
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (mon_job != job_id) begin
         mon_job       = job_id;
         stall_used    = 0;
         first_run_cyc = -1;
         last_hs_cyc   = -1;
      end
      if (bus.mv_run) begin
         run_cnt++;
         if (first_run_cyc < 0) first_run_cyc = cyc;
         check("mv_num_cnt", 160'(bus.mv_num_cnt), 160'(exp_cnt));
      end
      if (bus.res_valid) begin
         check("run_during_push", 160'(bus.mv_run), 160'(0));
         if (stall_tile >= 0 && int'(o_tile_idx) == stall_tile && stall_used < stall_n) begin
            bus.res_ready = 1'b0;
            stall_used++;
         end else begin
            bus.res_ready = 1'b1;
         end
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got data %0h with no expected entry", bus.res_data);
         end else begin
            check("res_data", 160'(bus.res_data), 160'(exp_q[0].data));
            check("res_last", 160'(bus.res_last), 160'(exp_q[0].last));
            check("res_tile_idx", 160'(o_tile_idx), 160'(exp_q[0].idx));
            if (bus.res_ready) begin
               void'(exp_q.pop_front());
               last_hs_cyc = cyc;
            end
         end
      end else begin
         bus.res_ready = 1'b1;
         check("last_without_valid", 160'(bus.res_last), 160'(0));
      end
      if (o_done) begin
         check("done_width", 160'(prev_done), 160'(0));
         done_cnt++;
      end
      prev_done = o_done;
   end

   // Mover model: goes busy after a run, returns done with results 4k+1..4k+4.
   int mv_job = 0;
   int mv_k = 0;
   always begin
      @(negedge clk);
      if (bus.mv_run) begin
         if (mv_job != job_id) begin
            mv_job = job_id;
            mv_k   = 0;
         end
         @(negedge clk);
         bus.mv_idle = 1'b0;
         if (!mv_hang) begin
            repeat (2) @(negedge clk);
            bus.mv_result_0 = RW'(4*mv_k+1);
            bus.mv_result_1 = RW'(4*mv_k+2);
            bus.mv_result_2 = RW'(4*mv_k+3);
            bus.mv_result_3 = RW'(4*mv_k+4);
            bus.mv_done     = 1'b1;
            @(negedge clk);
            bus.mv_done = 1'b0;
            bus.mv_idle = 1'b1;
         end
         mv_k++;
      end
   end

   task automatic check_all_zero(input string nm);
      check({nm, "_busy"},  160'(o_busy), 160'(0));
      check({nm, "_done"},  160'(o_done), 160'(0));
      check({nm, "_err"},   160'(o_err_timeout), 160'(0));
      check({nm, "_tile"},  160'(o_tile_idx), 160'(0));
      check({nm, "_run"},   160'(bus.mv_run), 160'(0));
      check({nm, "_cnt"},   160'(bus.mv_num_cnt), 160'(0));
      check({nm, "_valid"}, 160'(bus.res_valid), 160'(0));
      check({nm, "_data"},  160'(bus.res_data), 160'(0));
      check({nm, "_last"},  160'(bus.res_last), 160'(0));
   endtask

   task automatic pulse_start(input int nt, input int nc);
      i_num_tile = TB'(nt);
      i_num_cnt  = CB'(nc);
      i_start    = 1'b1;
      tick;
      i_start    = 1'b0;
   endtask

   task automatic wait_run(input int runs0, output int lcyc);
      bit seen = 1'b0;
      lcyc = -1;
      for (int i = 0; i < 30 && !seen; i++) begin
         if (run_cnt > runs0) begin
            seen = 1'b1;
            lcyc = cyc;
         end else tick;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL wait_run: no mover run within 30 cycles");
      end
   endtask

   // Full job: queue expectations, start, wait for o_done, then check latencies and counts.
   task automatic run_job(input int nt, input int nc, input int st_tile, input int st_n);
      int  sc, dc, runs0, dones0;
      bit  seen, zero;
      zero = (nt == 0 || nc == 0);
      job_id++;
      stall_tile = st_tile;
      stall_n    = st_n;
      exp_cnt    = CB'(nc);
      if (!zero)
         for (int t = 0; t < nt; t++)
            exp_q.push_back('{data: tile_data(t), last: (t == nt-1), idx: TB'(t)});
      runs0  = run_cnt;
      dones0 = done_cnt;
      sc     = cyc;
      pulse_start(nt, nc);
      seen = 1'b0;
      dc   = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         if (o_done) begin
            seen = 1'b1;
            dc   = cyc;
         end else tick;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL job_timeout: no o_done for tiles=%0d cnt=%0d", nt, nc);
      end else begin
         if (zero) check("zero_done_latency", 160'(dc - sc), 160'(1));
         else begin
            check("run_latency", 160'(first_run_cyc - sc), 160'(1));
            check("done_after_last_hs", 160'(dc - last_hs_cyc), 160'(1));
         end
         check("busy_in_done", 160'(o_busy), 160'(1));
         tick;
         check("done_pulse_end", 160'(o_done), 160'(0));
         check("busy_after_done", 160'(o_busy), 160'(0));
         check("run_count", 160'(run_cnt - runs0), 160'(zero ? 0 : nt));
         check("done_count", 160'(done_cnt - dones0), 160'(1));
         check("tile_idx_hold", 160'(o_tile_idx), 160'(zero ? 0 : nt-1));
         check("queue_empty", 160'(exp_q.size()), 160'(0));
      end
   endtask

   initial begin
      int runs0, dones0, lcyc;
      bus.mv_idle     = 1'b1;
      bus.mv_done     = 1'b0;
      bus.mv_result_0 = '0;
      bus.mv_result_1 = '0;
      bus.mv_result_2 = '0;
      bus.mv_result_3 = '0;
      repeat (3) tick;
      check_all_zero("reset");
      reset_n = 1'b1;
      tick;
      check_all_zero("post_reset");

      // Single tile, results 1,2,3,4, ready always high.
      run_job(1, 4, -1, 0);
      // Three tiles, ready withheld for 5 cycles on tile 1.
      run_job(3, 10, 1, 5);
      // Degenerate jobs finish without any mover run.
      run_job(0, 5, -1, 0);
      run_job(3, 0, -1, 0);

      // Watchdog: mover never completes.
      mv_hang = 1'b1;
      job_id++;
      stall_tile = -1;
      exp_cnt    = CB'(7);
      runs0      = run_cnt;
      pulse_start(2, 7);
      wait_run(runs0, lcyc);
      repeat (16) tick;
      check("wd_err_early", 160'(o_err_timeout), 160'(0));
      check("wd_busy_wait", 160'(o_busy), 160'(1));
      tick;
      check("wd_err_set", 160'(o_err_timeout), 160'(1));
      check("wd_err_busy", 160'(o_busy), 160'(1));
      bus.mv_idle = 1'b1;
      pulse_start(1, 3);
      tick;
      check("err_start_ignored", 160'(o_err_timeout), 160'(1));
      check("err_no_run", 160'(run_cnt - runs0), 160'(1));
      i_abort = 1'b1;
      tick;
      i_abort = 1'b0;
      check("abort_clears_err", 160'(o_err_timeout), 160'(0));
      check("abort_idle", 160'(o_busy), 160'(0));
      mv_hang = 1'b0;

      // Abort while results wait for ready.
      job_id++;
      stall_tile = 0;
      stall_n    = 100000;
      exp_cnt    = CB'(3);
      exp_q.push_back('{data: tile_data(0), last: 1'b0, idx: TB'(0)});
      pulse_start(2, 3);
      for (int i = 0; i < 30 && !bus.res_valid; i++) tick;
      check("push_reached", 160'(bus.res_valid), 160'(1));
      repeat (3) tick;
      dones0  = done_cnt;
      i_abort = 1'b1;
      tick;
      i_abort = 1'b0;
      check("abort_push_valid", 160'(bus.res_valid), 160'(0));
      check("abort_push_busy", 160'(o_busy), 160'(0));
      check("abort_keeps_data", 160'(bus.res_data), 160'({36'd1, 36'd2, 36'd3, 36'd4}));
      repeat (3) tick;
      check("abort_no_done", 160'(done_cnt - dones0), 160'(0));
      exp_q.delete();
      stall_n = 0;
      runs0   = run_cnt;
      bus.mv_idle = 1'b0;
      pulse_start(1, 9);
      check("start_not_idle_ignored", 160'(o_busy), 160'(0));
      tick;
      check("start_not_queued", 160'(o_busy), 160'(0));
      check("start_not_idle_no_run", 160'(run_cnt - runs0), 160'(0));
      bus.mv_idle = 1'b1;
      run_job(1, 9, -1, 0);

      // Asynchronous reset in the middle of WAIT.
      mv_hang = 1'b1;
      job_id++;
      exp_cnt = CB'(4);
      runs0   = run_cnt;
      pulse_start(1, 4);
      wait_run(runs0, lcyc);
      repeat (3) tick;
      check("pre_reset_busy", 160'(o_busy), 160'(1));
      #2 reset_n = 1'b0;
      #1 check_all_zero("async_reset");
      tick;
      reset_n     = 1'b1;
      mv_hang     = 1'b0;
      bus.mv_idle = 1'b1;
      tick;
      run_job(2, 6, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
